uart_tx: RTL

- Serial UART transmitter: 8 data bits, one start bit, one stop bit, no parity, LSB first. Companion to the design's UART receiver.
- Accepts bytes from the FIR output path through a small internal FIFO, so several filtered samples can be queued while a frame is on the line.
- Serialises each byte onto o_uarttx at CLKS_PER_BIT clocks per bit. Line idles high.

---
 rtl/uart_tx_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_tx.sv | 130 +++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART constants and state encodings, used by the transmitter and the receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

   localparam int UART_CLKS_PER_BIT    = 1250;
   localparam int UART_HALF_CLK_PERIOD = 625;

   // The receiver decodes the same values, so these encodings must stay fixed.
   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      TX_START_BIT = 3'd1,
      TX_DATA_BITS = 3'd2,
      TX_STOP_BIT  = 3'd3,
      CLEANUP      = 3'd4
   } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out bundle of the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: the producer may write only while o_txready is high.
interface uart_tx_if #(
   parameter int FIFO_AW = 2
);
   logic               i_txdatval;
   logic [7:0]         i_txbyte;
   logic               o_txready;
   logic               o_uarttx;
   logic               o_txactive;
   logic               o_txdone;
   logic [FIFO_AW:0]   o_fifo_count;

   modport master (
      output i_txdatval, i_txbyte,
      input  o_txready, o_uarttx, o_txactive, o_txdone, o_fifo_count
   );

   modport slave (
      input  i_txdatval, i_txbyte,
      output o_txready, o_uarttx, o_txactive, o_txdone, o_fifo_count
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small byte FIFO that queues bytes ahead of the serialiser.
// Latency: read data is registered and valid the cycle after i_rd; no fall-through.
// Backpressure: o_full is registered; a write while full is dropped with no state change.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int FIFO_AW    = 2
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wr,
   input  logic [7:0]         i_wdata,
   input  logic               i_rd,
   output logic [7:0]         o_rdata,
   output logic               o_full,
   output logic               o_empty,
   output logic [FIFO_AW:0]   o_count
);
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(FIFO_DEPTH);

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wptr_q, rptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full_q;
   logic [7:0]         rdata_q;
   logic               push, pop;

   assign push = i_wr && !full_q;
   assign pop  = i_rd && (count_q != '0);

   // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   // Pointers, count, full flag and read register; full is computed from the next count so it moves with o_count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (push)
            wptr_q <= wptr_q + 1'b1;
         if (pop) begin
            rdata_q <= mem_q[rptr_q];
            rptr_q  <= rptr_q + 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge i_clk) begin
      if (push)
         mem_q[wptr_q] <= i_wdata;
   end

   assign o_rdata = rdata_q;
   assign o_full  = full_q;
   assign o_empty = (count_q == '0);
   assign o_count = count_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, fed through a small byte FIFO.
// Latency: start bit on the line the cycle after the FIFO pop; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: o_txready drops when the FIFO is full; writes while full are dropped.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4,
   parameter int FIFO_AW      = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   uart_tx_if.slave   bus
);
   localparam int               CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             line_q, active_q, done_q;

   logic             fifo_rd, fifo_full, fifo_empty;
   logic [7:0]       fifo_rdata;
   logic [FIFO_AW:0] fifo_count;
   logic             bit_end;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (bus.i_txdatval),
      .i_wdata (bus.i_txbyte),
      .i_rd    (fifo_rd),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   assign fifo_rd = (state_q == IDLE) && !fifo_empty;
   assign bit_end = (cnt_q == CNT_MAX);

   // Frame sequencer: bit timing, shift register and all registered line/status outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         line_q   <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               line_q   <= 1'b1;
               active_q <= 1'b0;
               cnt_q    <= '0;
               if (!fifo_empty) begin
                  state_q  <= TX_START_BIT;
                  line_q   <= 1'b0;
                  active_q <= 1'b1;
               end
            end
            TX_START_BIT: begin
               // The popped byte appears on the registered FIFO output one cycle after the pop.
               if (cnt_q == '0)
                  shift_q <= fifo_rdata;
               if (bit_end) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  line_q  <= shift_q[0];
                  state_q <= TX_DATA_BITS;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            TX_DATA_BITS: begin
               if (bit_end) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     bit_q   <= '0;
                     line_q  <= 1'b1;
                     state_q <= TX_STOP_BIT;
                  end else begin
                     bit_q  <= bit_q + 1'b1;
                     line_q <= shift_q[bit_q + 3'd1];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            TX_STOP_BIT: begin
               line_q <= 1'b1;
               if (bit_end) begin
                  cnt_q    <= '0;
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= CLEANUP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            CLEANUP: begin
               line_q   <= 1'b1;
               active_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               line_q   <= 1'b1;
               active_q <= 1'b0;
               cnt_q    <= '0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_uarttx     = line_q;
   assign bus.o_txactive   = active_q;
   assign bus.o_txdone     = done_q;
   assign bus.o_txready    = !fifo_full;
   assign bus.o_fifo_count = fifo_count;

endmodule
